// File: rtl/seg7_mux_display.sv
// Sequential binary-to-BCD converter (shift-and-add-3) feeding a time-multiplexed,
// N-digit seven-segment display with sign, leading-zero blanking and overflow glyphs.
module seg7_mux_display #(
    parameter int N_DIGITS       = 4,
    parameter int DATA_W         = 12,
    parameter int DIV            = 100000,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   value_i,
    input  logic                load_i,
    input  logic                signed_i,
    input  logic                blank_lz_i,
    output logic                busy_o,
    output logic                overflow_o,
    output logic [N_DIGITS-1:0] an_o,
    output logic [7:0]          seg_o
);
    localparam int BW  = 4 * N_DIGITS;
    localparam int CW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int DCW = $clog2(DIV);
    localparam int IW  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [N_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [7:0]          SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [7:0]          P_MINUS = 8'h40;
    localparam logic [7:0]          P_E     = 8'h79;
    localparam logic [7:0]          P_BLANK = 8'h00;

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    state_t            state_q;
    logic              busy_q;
    logic [CW-1:0]     cnt_q;
    logic [DATA_W-1:0] mag_q;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic              cneg_q, cblank_q, covf_q;
    logic [BW-1:0]     disp_q;
    logic              neg_q, ovf_q, blank_q;
    logic [DATA_W-1:0] mag_neg;
    logic              shift_out;

    // Unsigned reading of the negated value is exact even for the most negative input.
    assign mag_neg = ~value_i + {{(DATA_W-1){1'b0}}, 1'b1};

    always_comb begin
        bcd_d = bcd_q;
        for (int i = 0; i < N_DIGITS; i++)
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        shift_out = bcd_d[BW-1];
        bcd_d     = {bcd_d[BW-2:0], mag_q[DATA_W-1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mag_q    <= '0;
            bcd_q    <= '0;
            cneg_q   <= 1'b0;
            cblank_q <= 1'b0;
            covf_q   <= 1'b0;
            disp_q   <= '0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            blank_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (load_i) begin
                    state_q  <= CONV;
                    busy_q   <= 1'b1;
                    cnt_q    <= '0;
                    bcd_q    <= '0;
                    covf_q   <= 1'b0;
                    cblank_q <= blank_lz_i;
                    cneg_q   <= signed_i & value_i[DATA_W-1];
                    mag_q    <= (signed_i && value_i[DATA_W-1]) ? mag_neg : value_i;
                end
                CONV: begin
                    bcd_q  <= bcd_d;
                    mag_q  <= mag_q << 1;
                    covf_q <= covf_q | shift_out;
                    if (cnt_q == CW'(DATA_W - 1)) state_q <= COMMIT;
                    else                          cnt_q   <= cnt_q + 1'b1;
                end
                COMMIT: begin
                    disp_q  <= bcd_q;
                    neg_q   <= cneg_q;
                    blank_q <= cblank_q;
                    // A negative value needs a free top digit for its '-'.
                    ovf_q   <= covf_q | (cneg_q && (bcd_q[BW-1 -: 4] != 4'd0));
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    function automatic logic [7:0] glyph(input logic [3:0] d);
        case (d)
            4'd0: glyph = 8'h3F;  4'd1: glyph = 8'h06;
            4'd2: glyph = 8'h5B;  4'd3: glyph = 8'h4F;
            4'd4: glyph = 8'h66;  4'd5: glyph = 8'h6D;
            4'd6: glyph = 8'h7D;  4'd7: glyph = 8'h07;
            4'd8: glyph = 8'h7F;  4'd9: glyph = 8'h6F;
            default: glyph = P_BLANK;
        endcase
    endfunction

    logic [DCW-1:0]      div_q;
    logic [IW-1:0]       idx_q;
    logic [N_DIGITS-1:0] an_q, an_d;
    logic [7:0]          seg_q, seg_d, pat;
    int                  msd, cur;

    always_comb begin
        msd = 0;
        for (int i = 0; i < N_DIGITS; i++)
            if (disp_q[4*i +: 4] != 4'd0) msd = i;
        cur = int'(idx_q);
        if (ovf_q)
            pat = P_E;
        else if (blank_q && cur > msd)
            pat = (neg_q && cur == msd + 1) ? P_MINUS : P_BLANK;
        else if (neg_q && !blank_q && cur == N_DIGITS - 1)
            pat = P_MINUS;
        else
            pat = glyph(disp_q[4*cur +: 4]);
        seg_d = (SEG_ACTIVE_LOW != 0) ? ~pat : pat;
        an_d  = (AN_ACTIVE_LOW != 0) ? ~(N_DIGITS'(1) << idx_q) : (N_DIGITS'(1) << idx_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            idx_q <= '0;
            an_q  <= AN_OFF;
            seg_q <= SEG_OFF;
        end else begin
            if (div_q == DCW'(DIV - 1)) begin
                div_q <= '0;
                idx_q <= (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
            end else begin
                div_q <= div_q + 1'b1;
            end
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign busy_o     = busy_q;
    assign overflow_o = ovf_q;
    assign an_o       = an_q;
    assign seg_o      = seg_q;
endmodule

// File: tb/tb_seg7_mux_display.sv
// Directed bench for seg7_mux_display: three instances (4, 3 and 5 digits) share
// one stimulus stream so digit-count dependent overflow and blanking are covered.
module tb_seg7_mux_display;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] value = '0;
    logic        load = 1'b0, sgn = 1'b0, blk = 1'b0;
    logic        busy4, busy3, busy5, ovf4, ovf3, ovf5;
    logic [3:0]  an4;
    logic [2:0]  an3;
    logic [4:0]  an5;
    logic [7:0]  seg4, seg3, seg5;
    logic [7:0]  s4 [4];
    logic [7:0]  s3 [3];
    logic [7:0]  s5 [5];
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    seg7_mux_display #(.N_DIGITS(4), .DATA_W(12), .DIV(4)) dut4 (
        .clk(clk), .rst(rst), .value_i(value), .load_i(load), .signed_i(sgn),
        .blank_lz_i(blk), .busy_o(busy4), .overflow_o(ovf4), .an_o(an4), .seg_o(seg4));
    seg7_mux_display #(.N_DIGITS(3), .DATA_W(12), .DIV(4)) dut3 (
        .clk(clk), .rst(rst), .value_i(value), .load_i(load), .signed_i(sgn),
        .blank_lz_i(blk), .busy_o(busy3), .overflow_o(ovf3), .an_o(an3), .seg_o(seg3));
    seg7_mux_display #(.N_DIGITS(5), .DATA_W(12), .DIV(4)) dut5 (
        .clk(clk), .rst(rst), .value_i(value), .load_i(load), .signed_i(sgn),
        .blank_lz_i(blk), .busy_o(busy5), .overflow_o(ovf5), .an_o(an5), .seg_o(seg5));

    // Remember the last segment pattern seen on each enabled digit.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) if (an4 == ~(4'b1 << k)) s4[k] = seg4;
        for (int k = 0; k < 3; k++) if (an3 == ~(3'b1 << k)) s3[k] = seg3;
        for (int k = 0; k < 5; k++) if (an5 == ~(5'b1 << k)) s5[k] = seg5;
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_digits(input string tag, input int n, input logic [39:0] exp);
        logic [7:0] obs;
        for (int k = 0; k < n; k++) begin
            obs = (n == 3) ? s3[k] : (n == 4) ? s4[k] : s5[k];
            chk($sformatf("%s_d%0d", tag, k), {24'h0, obs}, {24'h0, exp[8*k +: 8]});
        end
    endtask

    task automatic do_load(input logic [11:0] v, input logic s, input logic b);
        value = v; sgn = s; blk = b; load = 1'b1;
        tick;
        load = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (busy4 && n < 40) begin
            n++;
            tick;
        end
    endtask

    task automatic settle;
        repeat (24) tick;
    endtask

    initial begin
        int         n;
        logic [3:0] e_an;

        tick; tick;
        chk("rst_an", {28'h0, an4}, 32'hF);
        chk("rst_seg", {24'h0, seg4}, 32'hFF);
        chk("rst_busy", {31'h0, busy4}, 32'h0);
        chk("rst_ovf", {31'h0, ovf4}, 32'h0);
        rst = 1'b0;

        for (int c = 0; c < 20; c++) begin
            tick;
            e_an = ~(4'b1 << ((c / 4) % 4));
            chk($sformatf("scan_an_c%0d", c), {28'h0, an4}, {28'h0, e_an});
            chk($sformatf("scan_seg_c%0d", c), {24'h0, seg4}, 32'hC0);
        end

        do_load(12'd1234, 1'b0, 1'b0);
        chk("busy_start", {31'h0, busy4}, 32'h1);
        wait_done(n);
        chk("busy_len", n, 13);
        chk("ovf_1234_n4", {31'h0, ovf4}, 32'h0);
        chk("ovf_1234_n3", {31'h0, ovf3}, 32'h1);
        settle;
        chk_digits("u1234_n4", 4, {8'hF9, 8'hA4, 8'hB0, 8'h99});
        chk_digits("u1234_n5", 5, {8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99});
        chk_digits("u1234_n3", 3, {8'h86, 8'h86, 8'h86});

        do_load(12'hFD6, 1'b1, 1'b1);
        wait_done(n);
        chk("done_m42b", {31'h0, busy4}, 32'h0);
        chk("ovf_m42b", {31'h0, ovf4}, 32'h0);
        settle;
        chk_digits("m42b_n4", 4, {8'hFF, 8'hBF, 8'h99, 8'hA4});
        chk_digits("m42b_n5", 5, {8'hFF, 8'hFF, 8'hBF, 8'h99, 8'hA4});
        chk_digits("m42b_n3", 3, {8'hBF, 8'h99, 8'hA4});

        do_load(12'hFD6, 1'b1, 1'b0);
        wait_done(n);
        chk("done_m42", {31'h0, busy4}, 32'h0);
        settle;
        chk_digits("m42_n4", 4, {8'hBF, 8'hC0, 8'h99, 8'hA4});

        do_load(12'hFFF, 1'b0, 1'b0);
        wait_done(n);
        chk("ovf_4095_n4", {31'h0, ovf4}, 32'h0);
        chk("ovf_4095_n3", {31'h0, ovf3}, 32'h1);
        settle;
        chk_digits("u4095_n4", 4, {8'h99, 8'hC0, 8'h90, 8'h92});
        chk_digits("u4095_n3", 3, {8'h86, 8'h86, 8'h86});

        do_load(12'hC18, 1'b1, 1'b1);
        wait_done(n);
        chk("ovf_m1000_n4", {31'h0, ovf4}, 32'h1);
        chk("ovf_m1000_n5", {31'h0, ovf5}, 32'h0);
        settle;
        chk_digits("m1000_n4", 4, {8'h86, 8'h86, 8'h86, 8'h86});
        chk_digits("m1000_n5", 5, {8'hBF, 8'hF9, 8'hC0, 8'hC0, 8'hC0});

        do_load(12'd1234, 1'b0, 1'b0);
        repeat (3) tick;
        do_load(12'd7, 1'b0, 1'b0);
        wait_done(n);
        chk("done_ign", {31'h0, busy4}, 32'h0);
        tick;
        chk("no_restart", {31'h0, busy4}, 32'h0);
        settle;
        chk_digits("ignore_n4", 4, {8'hF9, 8'hA4, 8'hB0, 8'h99});

        do_load(12'd567, 1'b0, 1'b0);
        repeat (5) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("abort_busy", {31'h0, busy4}, 32'h0);
        chk("abort_an", {28'h0, an4}, 32'hF);
        settle;
        chk("abort_idle", {31'h0, busy4}, 32'h0);
        chk("abort_ovf", {31'h0, ovf4}, 32'h0);
        chk_digits("abort_n4", 4, {8'hC0, 8'hC0, 8'hC0, 8'hC0});

        do_load(12'h800, 1'b1, 1'b1);
        wait_done(n);
        chk("ovf_m2048_n4", {31'h0, ovf4}, 32'h1);
        chk("ovf_m2048_n5", {31'h0, ovf5}, 32'h0);
        settle;
        chk_digits("m2048_n5", 5, {8'hBF, 8'hA4, 8'hC0, 8'h99, 8'h80});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
